// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, fetches 16-bit words over a
// req/ack port, resolves JMP/CALL/RET/HALT internally with a small return-address stack
// and hands every other instruction to the decoder over a valid/ready issue port.
module fetch_sequencer #(
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    localparam int unsigned        SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              issue_valid,
    output logic [15:0]       issue_instr,
    output logic [ADDR_W-1:0] issue_pc,
    input  logic              issue_ready,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned     IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_state_d;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_d;
    logic [SP_W-1:0]   r_sp;
    logic [SP_W-1:0]   w_sp_d;
    logic [15:0]       r_instr;
    logic [15:0]       w_instr_d;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_push;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;
    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_target;

    // pc+1 wraps naturally at ADDR_W bits; it is both the return address and the step.
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    // Indices are only used when the push/pop is legal, so truncation is safe.
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_op       = imem_rdata[15:12];
    assign w_target   = ADDR_W'(imem_rdata[7:0]);

    // Next-state decode: control opcodes are resolved on the acknowledging edge.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_sp_d    = r_sp;
        w_instr_d = r_instr;
        w_push    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    case (w_op)
                        OP_JMP: begin
                            w_pc_d = w_target;
                        end
                        OP_CALL: begin
                            if (r_sp == SP_FULL) begin
                                w_state_d = S_FAULT;
                            end else begin
                                w_push = 1'b1;
                                w_sp_d = r_sp + SP_W'(1);
                                w_pc_d = w_target;
                            end
                        end
                        OP_RET: begin
                            if (r_sp == '0) begin
                                w_state_d = S_FAULT;
                            end else begin
                                w_pc_d = r_stack[w_pop_idx];
                                w_sp_d = r_sp - SP_W'(1);
                            end
                        end
                        OP_HALT: begin
                            w_state_d = S_HALTED;
                        end
                        default: begin
                            w_instr_d = imem_rdata;
                            w_state_d = S_ISSUE;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (start) begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_d = S_FAULT;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Control state, pc, stack pointer and held instruction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_sp    <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_sp    <= w_sp_d;
            r_instr <= w_instr_d;
        end
    end

    // Return-address storage; contents are don't-care after reset and left intact on pop.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign issue_valid = (r_state == S_ISSUE);
    assign issue_instr = r_instr;
    assign issue_pc    = r_pc;
    assign halted      = (r_state == S_HALTED);
    assign fault       = (r_state == S_FAULT);
    assign pc          = r_pc;
    assign sp          = r_sp;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level reference model fills expected
// fetch/issue/halt queues; a monitor pops and compares whenever the DUT transfers.
module tb_fetch_sequencer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [7:0]  issue_pc;
    logic        issue_ready;
    logic        halted;
    logic        fault;
    logic [7:0]  pc;
    logic [2:0]  sp;

    fetch_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_PC    (8'h00)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .issue_ready (issue_ready),
        .halted      (halted),
        .fault       (fault),
        .pc          (pc),
        .sp          (sp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [256];

    // Expected-response queues filled by the reference model.
    logic [7:0]  exp_faddr [$];
    int          exp_fsp   [$];
    logic [15:0] exp_iw    [$];
    logic [7:0]  exp_ip    [$];
    logic [7:0]  exp_halt  [$];
    logic        m_fault;
    logic [7:0]  exp_fault_pc;
    int          exp_fault_sp;
    logic        fault_seen;

    int fetch_cyc [$];
    int issue_cyc [$];
    int v10_cnt;
    int cyc;

    // Driver controls.
    int          ack_mode;
    logic        rdy_rand;
    logic        start_rand;
    logic [7:0]  hold_pc;
    int          hold_cnt;
    int          wcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
    endtask

    // Program-level model: walks the program with a queue as the return stack.
    task automatic run_model(input int cap);
        logic [7:0]  p;
        logic [15:0] w;
        logic [7:0]  stk [$];
        p = 8'h00;
        m_fault = 1'b0;
        for (int n = 0; n < cap; n++) begin
            w = mem[p];
            exp_faddr.push_back(p);
            exp_fsp.push_back(stk.size());
            case (w[15:12])
                4'hA: p = w[7:0];
                4'hC: begin
                    if (stk.size() == 4) begin
                        m_fault = 1'b1;
                        exp_fault_pc = p;
                        exp_fault_sp = 4;
                        return;
                    end
                    stk.push_back(p + 8'd1);
                    p = w[7:0];
                end
                4'hD: begin
                    if (stk.size() == 0) begin
                        m_fault = 1'b1;
                        exp_fault_pc = p;
                        exp_fault_sp = 0;
                        return;
                    end
                    p = stk.pop_back();
                end
                4'hF: begin
                    exp_halt.push_back(p);
                    p = p + 8'd1;
                end
                default: begin
                    exp_iw.push_back(w);
                    exp_ip.push_back(p);
                    p = p + 8'd1;
                end
            endcase
        end
    endtask

    // Memory / decoder / start driver, updated just after each rising edge.
    initial begin
        imem_ack = 1'b0;
        imem_rdata = '0;
        issue_ready = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) begin
                imem_rdata = mem[imem_addr];
                case (ack_mode)
                    0: imem_ack = 1'b1;
                    1: imem_ack = 1'($urandom_range(0, 1));
                    default: begin
                        if (wcnt == 3) begin
                            imem_ack = 1'b1;
                            wcnt = 0;
                        end else begin
                            imem_ack = 1'b0;
                            wcnt++;
                        end
                    end
                endcase
            end else begin
                imem_rdata = 16'($urandom);
                imem_ack = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
            if (issue_valid) begin
                if (issue_pc == hold_pc && hold_cnt < 3) begin
                    issue_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    issue_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                issue_ready = 1'($urandom_range(0, 1));
            end
            if (start_rand) start = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: compares every transfer against the scoreboard queues.
    initial begin
        logic       prev_req, prev_ack, prev_valid, prev_ready, prev_halted, prev_fault;
        logic [7:0] prev_addr, prev_ip;
        logic [15:0] prev_iw;
        prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0;
        prev_halted = 0; prev_fault = 0; prev_addr = 0; prev_ip = 0; prev_iw = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                prev_req = 0; prev_valid = 0; prev_halted = 0; prev_fault = 0;
            end else begin
                if (prev_req && !prev_ack && imem_req)
                    chk("fetch_addr_stable", imem_addr, prev_addr);
                if (prev_valid && !prev_ready && issue_valid) begin
                    chk("issue_instr_stable", issue_instr, prev_iw);
                    chk("issue_pc_stable", issue_pc, prev_ip);
                end
                if (imem_req && imem_ack) begin
                    fetch_cyc.push_back(cyc);
                    if (exp_faddr.size() > 0) begin
                        chk("fetch_addr", imem_addr, exp_faddr.pop_front());
                        chk("fetch_sp", sp, exp_fsp.pop_front());
                    end else if (m_fault) begin
                        fail_evt("extra_fetch");
                    end
                end
                if (issue_valid && issue_ready) begin
                    issue_cyc.push_back(cyc);
                    if (exp_iw.size() > 0) begin
                        chk("issue_instr", issue_instr, exp_iw.pop_front());
                        chk("issue_pc", issue_pc, exp_ip.pop_front());
                    end else if (m_fault) begin
                        fail_evt("extra_issue");
                    end
                end
                if (issue_valid && issue_pc == 8'h10) v10_cnt++;
                if (halted && !prev_halted) begin
                    chk("halt_req_low", imem_req, 1'b0);
                    if (exp_halt.size() > 0) chk("halt_pc", pc, exp_halt.pop_front());
                    else if (m_fault) fail_evt("extra_halt");
                end
                if (fault && !prev_fault) begin
                    if (m_fault) begin
                        chk("fault_pc", pc, exp_fault_pc);
                        chk("fault_sp", sp, exp_fault_sp);
                        chk("fault_req_low", imem_req, 1'b0);
                        fault_seen = 1'b1;
                    end else begin
                        fail_evt("unexpected_fault");
                    end
                end
                prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
                prev_valid = issue_valid; prev_ready = issue_ready;
                prev_iw = issue_instr; prev_ip = issue_pc;
                prev_halted = halted; prev_fault = fault;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, 8'h00);
        chk({tag, "_issue_valid"}, issue_valid, 1'b0);
        chk({tag, "_issue_instr"}, issue_instr, 16'h0000);
        chk({tag, "_issue_pc"}, issue_pc, 8'h00);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_fault"}, fault, 1'b0);
        chk({tag, "_pc"}, pc, 8'h00);
        chk({tag, "_sp"}, sp, 3'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        start = 1'b0;
        start_rand = 1'b0;
        hold_cnt = 3;
        exp_faddr.delete(); exp_fsp.delete(); exp_iw.delete(); exp_ip.delete();
        exp_halt.delete(); fetch_cyc.delete(); issue_cyc.delete();
        m_fault = 1'b0;
        fault_seen = 1'b0;
        v10_cnt = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(exp_faddr.size() == 0 && (!m_fault || fault_seen)) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d fetches pending, expected 0", tag,
                     exp_faddr.size());
        end
    endtask

    task automatic gen_random_mem();
        for (int a = 0; a < 256; a++) begin
            int r;
            int k;
            logic [3:0] op;
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 11);
            if (r < 45) op = (k == 10) ? 4'hB : (k == 11) ? 4'hE : 4'(k);
            else if (r < 60) op = 4'hA;
            else if (r < 75) op = 4'hC;
            else if (r < 88) op = 4'hD;
            else op = 4'hF;
            mem[a] = {op, 4'($urandom), 8'($urandom)};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        start = 1'b0;
        ack_mode = 0;
        rdy_rand = 1'b0;
        start_rand = 1'b0;
        hold_pc = 8'h10;
        hold_cnt = 3;
        m_fault = 1'b0;
        fault_seen = 1'b0;
        v10_cnt = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("por");

        // Directed program: linear issue, JMP with backpressure, CALL/RET, HALT, wrap.
        mem[8'h00] = 16'h1234; mem[8'h01] = 16'h2000; mem[8'h02] = 16'h3001;
        mem[8'h03] = 16'hA010; mem[8'h10] = 16'h5555; mem[8'h11] = 16'hA005;
        mem[8'h05] = 16'hC040; mem[8'h40] = 16'hD000; mem[8'h06] = 16'hA020;
        mem[8'h20] = 16'hF000; mem[8'h21] = 16'hA0FF; mem[8'hFF] = 16'h7777;
        run_model(13);
        hold_cnt = 0;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_req", imem_req, 1'b0);
        end
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("start_req", imem_req, 1'b1);
        chk("start_addr", imem_addr, 8'h00);
        start_rand = 1'b1;
        wait_done("directed", 400);
        if (fetch_cyc.size() >= 9 && issue_cyc.size() >= 3) begin
            chk("linear_fetch_gap0", fetch_cyc[1] - fetch_cyc[0], 2);
            chk("linear_fetch_gap1", fetch_cyc[2] - fetch_cyc[1], 2);
            chk("linear_issue_gap", issue_cyc[2] - issue_cyc[1], 2);
            chk("jmp_one_cycle", fetch_cyc[4] - fetch_cyc[3], 1);
            chk("backpressure_gap", fetch_cyc[5] - fetch_cyc[4], 5);
            chk("call_one_cycle", fetch_cyc[7] - fetch_cyc[6], 1);
            chk("ret_one_cycle", fetch_cyc[8] - fetch_cyc[7], 1);
        end else begin
            chk("directed_fetch_count", fetch_cyc.size(), 9);
        end
        chk("held_valid_cycles", v10_cnt, 4);

        // Five nested CALLs overflow a 4-deep stack; fault is terminal.
        do_reset();
        mem[0] = 16'hC001; mem[1] = 16'hC002; mem[2] = 16'hC003;
        mem[3] = 16'hC004; mem[4] = 16'hC005;
        ack_mode = 1; rdy_rand = 1'b1;
        run_model(20);
        @(posedge clk); #2 start = 1'b1;
        wait_done("overflow", 300);
        repeat (10) begin
            @(negedge clk);
            chk("fault_sticky", fault, 1'b1);
            chk("fault_no_req", imem_req, 1'b0);
            chk("fault_sp_hold", sp, 3'd4);
        end
        start = 1'b0;
        chk("overflow_issue_drained", exp_iw.size(), 0);

        // RET with an empty stack.
        do_reset();
        mem[0] = 16'hD000;
        run_model(5);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done("underflow", 100);
        @(negedge clk);
        chk("underflow_fault", fault, 1'b1);

        // Asynchronous reset in the middle of a slow fetch.
        do_reset();
        mem[8'h00] = 16'hA030; mem[8'h30] = 16'h1111;
        ack_mode = 2; rdy_rand = 1'b0;
        run_model(2);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_addr == 8'h30) && n < 50);
        chk("pre_reset_addr", imem_addr, 8'h30);
        chk("pre_reset_req", imem_req, 1'b1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("async");

        // Randomised programs with random memory latency, backpressure and start.
        for (int run = 0; run < 12; run++) begin
            do_reset();
            gen_random_mem();
            ack_mode = 1;
            rdy_rand = 1'b1;
            run_model(120);
            start_rand = 1'b1;
            wait_done("random", 3000);
            if (m_fault) begin
                repeat (2) @(negedge clk);
                chk("random_issue_drained", exp_iw.size(), 0);
                chk("random_halt_drained", exp_halt.size(), 0);
            end
        end
        start_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the 16-bit custom processor. It owns the 8-bit program counter and fetches 16-bit instructions over a request/acknowledge port. It resolves control-flow opcodes (JMP, CALL, RET, HALT) internally using a small return-address stack. All other instructions go to the decode/execute stage over a valid/ready issue port. It sits between instruction memory and the decoder and replaces free-running PC sequencing with a stallable, handshaked front end.

## Interface
- ADDR_W, 8, program-counter and address width
- STACK_DEPTH, 4, return-address stack entries; SP_W = clog2(STACK_DEPTH+1)
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  system clock, all state updates on posedge
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  level-sampled run request; honoured in IDLE and HALTED only
- imem_req  out  1  fetch request; high exactly while state is FETCH
- imem_addr  out  ADDR_W  fetch address, equals pc
- imem_ack  in  1  fetch complete this cycle; only meaningful while imem_req=1
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- issue_valid  out  1  instruction offered to decoder; high exactly while state is ISSUE
- issue_instr  out  16  held instruction word
- issue_pc  out  ADDR_W  address of the held instruction
- issue_ready  in  1  decoder accepts the offered instruction
- halted  out  1  high in HALTED
- fault  out  1  high in FAULT (stack overflow/underflow), sticky
- pc  out  ADDR_W  current program counter
- sp  out  SP_W  return-stack occupancy

## Operation
- Opcode is instr[15:12]; target is instr[7:0]. Control opcodes: 4'hA JMP, 4'hC CALL, 4'hD RET, 4'hF HALT. All others are issued.
- States: IDLE, FETCH, ISSUE, HALTED, FAULT. Reset state is IDLE.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1 and imem_addr=pc, held stable until a cycle with imem_ack=1. On that edge, decode imem_rdata:
  - JMP: pc<=target; remain in FETCH.
  - CALL with sp<STACK_DEPTH: stack[sp]<=pc+1; sp<=sp+1; pc<=target; remain in FETCH.
  - CALL with sp==STACK_DEPTH: go to FAULT; pc and sp unchanged.
  - RET with sp>0: pc<=stack[sp-1]; sp<=sp-1; remain in FETCH.
  - RET with sp==0: go to FAULT.
  - HALT: go to HALTED; pc stays at the HALT address.
  - Other opcodes: issue_instr<=imem_rdata; go to ISSUE.
- ISSUE: issue_valid=1; issue_instr and issue_pc(=pc) held stable until issue_ready=1. On that edge: pc<=pc+1, then go to FETCH.
- HALTED: start=1 -> pc<=pc+1, then go to FETCH.
- FAULT: terminal. start and all inputs are ignored; only rstn exits.
- Arithmetic: pc+1 and stored return addresses are modulo 2^ADDR_W (8'hFF -> 8'h00). Stack contents are not cleared on pop.
- Control opcodes never appear on the issue port.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, issue_valid=0, issue_instr=0, issue_pc=RESET_PC, halted=0, fault=0, pc=RESET_PC, sp=0. Stack contents are don't-care.
- Reset mid-operation takes effect asynchronously. An outstanding fetch or issue is abandoned, and imem_req/issue_valid drop with rstn.
- Start is sampled at cycle N; imem_req=1 in cycle N+1.
- Zero-wait memory (ack in the same cycle as req) with issue_ready=1 gives 2 cycles per issued instruction and 1 cycle per JMP/CALL/RET.
- Back-to-back control opcodes keep imem_req high continuously. imem_addr changes on the edge after each ack, and each req&ack cycle counts as exactly one transfer.
- imem_ack while imem_req=0 is ignored. issue_ready while issue_valid=0 is ignored.
- halted and fault assert in the cycle after the acknowledging edge. imem_req is 0 in that same cycle.
- Outputs are decoded from registered state; there are no combinational input-to-output paths.

## Test plan
- Reset/start: hold rstn=0 -> all outputs at reset values with pc=0. Release rstn, pulse start at cycle 3 -> imem_req=1 and imem_addr=0 at cycle 4.
- Linear issue: memory 0x00..0x02 = 16'h1234, 16'h2000, 16'h3001; zero-wait memory; issue_ready=1 -> issue_pc 0, 1, 2 with matching issue_instr, two cycles apart.
- JMP with backpressure: 0x03=16'hA010 and 0x10=16'h5555; hold issue_ready=0 for 3 cycles -> next fetch address is 0x10. issue_valid stays 1 and issue_instr stays 16'h5555 for 3 cycles. After acceptance, the next fetch is 0x11.
- CALL/RET: 0x05=16'hC040 and 0x40=16'hD000 -> fetch sequence 0x05, 0x40, 0x06; sp goes 0 -> 1 -> 0; nothing is issued for either opcode.
- Stack faults: with STACK_DEPTH=4, chain five CALLs -> after the fifth ack, fault=1, sp=4, imem_req=0 permanently, and start is ignored. In a separate run, RET at sp=0 -> fault=1.
- HALT and wrap: 0x20=16'hF000 -> halted=1 and pc=0x20; pulse start -> fetch 0x21. An ordinary instruction at 0xFF, once accepted, -> next fetch 0x00. Assert rstn=0 mid-FETCH with a 3-cycle-wait memory -> imem_req drops immediately and pc=0.
